// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg -- shared definitions for the switch debouncer.
//   SW_N          : default number of switch bits (cpu board SW[9:0])
//   SW_DB_CYCLES  : default persistence, in clocks, before a new level is accepted
//   db_state_e    : per-bit debounce FSM state
package sw_debounce_pkg;

  localparam int unsigned SW_N         = 10;
  localparam int unsigned SW_DB_CYCLES = 16;

  typedef enum logic {
    STABLE  = 1'b0,  // synchronized input agrees with debounced output
    PENDING = 1'b1   // synchronized input differs; persistence being counted
  } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit -- debouncer for a single switch bit.
//   i_clk      : rising-edge system clock
//   i_n_reset  : asynchronous active-low reset
//   i_sw_raw   : raw asynchronous switch level
//   o_sw_db    : debounced level, updated after DB_CYCLES consecutive mismatches
//   o_rise     : one-cycle pulse on an accepted 0->1 change
//   o_fall     : one-cycle pulse on an accepted 1->0 change
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = SW_DB_CYCLES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_n_reset,
  input  logic i_sw_raw,
  output logic o_sw_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned   CW   = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;

  logic          w_diff;
  db_state_e     w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_db_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

  assign w_diff = (r_sync2 != r_db);

  // State register, synchronizer and registered outputs.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
      r_state <= STABLE;
      r_cnt   <= '0;
      r_db    <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_sw_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state: the counter only ever reaches LAST while the mismatch persists,
  // and the accepting edge clears it, so it cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      STABLE: begin
        if (w_diff) begin
          w_state_nxt = PENDING;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      PENDING: begin
        if (!w_diff) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
    endcase
  end

  // Outputs: pulses are registered on the same edge that loads the new level.
  always_comb begin
    w_db_nxt   = w_accept ? r_sync2 : r_db;
    w_rise_nxt = w_accept &  r_sync2;
    w_fall_nxt = w_accept & ~r_sync2;
  end

  assign o_sw_db = r_db;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce -- N-bit switch debouncer for the cpu board SW inputs.
//   clk        : rising-edge system clock
//   n_reset    : asynchronous active-low reset
//   sw_raw     : raw, asynchronous, bouncing switch levels
//   sw_db      : debounced, clk-synchronous switch levels (drives cpu SW)
//   rise       : per-bit one-cycle pulse on an accepted 0->1 change
//   fall       : per-bit one-cycle pulse on an accepted 1->0 change
//   sw_changed : one-cycle pulse, OR of all rise and fall bits
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned    N         = SW_N,
  parameter int unsigned    DB_CYCLES = SW_DB_CYCLES,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         sw_changed
);

  for (genvar g = 0; g < N; g++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .RESET_VAL (RESET_VAL[g])
    ) u_bit (
      .i_clk     (clk),
      .i_n_reset (n_reset),
      .i_sw_raw  (sw_raw[g]),
      .o_sw_db   (sw_db[g]),
      .o_rise    (rise[g]),
      .o_fall    (fall[g])
    );
  end

  // rise/fall are registered, so this OR is a clean single-cycle pulse.
  assign sw_changed = |(rise | fall);

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce -- self-checking bench for sw_debounce (N=10, DB_CYCLES=4).
// Stimulus is a table of {reset, raw, repeat, expected outputs} records;
// expectations are queued at drive time and checked one edge later.
module tb_sw_debounce;

  localparam int unsigned N   = 10;
  localparam int unsigned DBC = 4;

  typedef struct {
    logic [N-1:0] db;
    logic [N-1:0] rs;
    logic [N-1:0] fl;
    logic         ch;
    int           id;
  } exp_t;

  typedef struct {
    logic         rn;
    logic [N-1:0] raw;
    int unsigned  cnt;
    logic [N-1:0] db;
    logic [N-1:0] rs;
    logic [N-1:0] fl;
    logic         ch;
  } vec_t;

  logic         clk = 1'b0;
  logic         n_reset = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_db;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         sw_changed;

  int n_vec  = 0;
  int n_miss = 0;
  int seq_id = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  sw_debounce #(
    .N         (N),
    .DB_CYCLES (DBC),
    .RESET_VAL ({N{1'b0}})
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .sw_raw     (sw_raw),
    .sw_db      (sw_db),
    .rise       (rise),
    .fall       (fall),
    .sw_changed (sw_changed)
  );

  task automatic cmp(input exp_t e, input string tag);
    n_vec++;
    if (sw_db !== e.db || rise !== e.rs || fall !== e.fl || sw_changed !== e.ch) begin
      n_miss++;
      $display("FAIL %s #%0d: got db=%h rise=%h fall=%h chg=%b, want db=%h rise=%h fall=%h chg=%b",
               tag, e.id, sw_db, rise, fall, sw_changed, e.db, e.rs, e.fl, e.ch);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after the next edge.
  task automatic step(input logic rn, input logic [N-1:0] raw, input logic [N-1:0] db,
                      input logic [N-1:0] rs, input logic [N-1:0] fl, input logic ch);
    exp_t e;
    @(negedge clk);
    n_reset = rn;
    sw_raw  = raw;
    e = '{db: db, rs: rs, fl: fl, ch: ch, id: seq_id};
    seq_id++;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      cmp(mon_e, "edge");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d want 0", sb_q.size());
    $fatal(1);
  end

  initial begin
    vec_t tbl [0:14];
    exp_t z;
    z = '{db: '0, rs: '0, fl: '0, ch: 1'b0, id: -1};

    tbl[0]  = '{1'b0, 10'h3FF, 3, 10'h000, 10'h000, 10'h000, 1'b0}; // reset with all switches on
    tbl[1]  = '{1'b1, 10'h000, 4, 10'h000, 10'h000, 10'h000, 1'b0}; // release: no pulses
    tbl[2]  = '{1'b1, 10'h001, 3, 10'h000, 10'h000, 10'h000, 1'b0}; // 3-clock glitch on bit 0
    tbl[3]  = '{1'b1, 10'h000, 8, 10'h000, 10'h000, 10'h000, 1'b0}; // glitch rejected
    tbl[4]  = '{1'b1, 10'h011, 5, 10'h000, 10'h000, 10'h000, 1'b0}; // simultaneous 0 -> 17
    tbl[5]  = '{1'b1, 10'h011, 1, 10'h011, 10'h011, 10'h000, 1'b1};
    tbl[6]  = '{1'b1, 10'h011, 3, 10'h011, 10'h000, 10'h000, 1'b0};
    tbl[7]  = '{1'b1, 10'h019, 5, 10'h011, 10'h000, 10'h000, 1'b0}; // bit 3 rises, k..k+4
    tbl[8]  = '{1'b1, 10'h019, 1, 10'h019, 10'h008, 10'h000, 1'b1}; // accepted at k+5
    tbl[9]  = '{1'b1, 10'h019, 3, 10'h019, 10'h000, 10'h000, 1'b0};
    tbl[10] = '{1'b1, 10'h011, 2, 10'h019, 10'h000, 10'h000, 1'b0}; // bit 3 falls
    tbl[11] = '{1'b1, 10'h019, 1, 10'h019, 10'h000, 10'h000, 1'b0}; // bounce seen at count 2
    tbl[12] = '{1'b1, 10'h011, 5, 10'h019, 10'h000, 10'h000, 1'b0}; // count restarts
    tbl[13] = '{1'b1, 10'h011, 1, 10'h011, 10'h000, 10'h008, 1'b1};
    tbl[14] = '{1'b1, 10'h011, 3, 10'h011, 10'h000, 10'h000, 1'b0};

    // Reset is asynchronous: outputs clear before any clock edge.
    #2;
    n_reset = 1'b0;
    sw_raw  = '1;
    #1;
    cmp(z, "reset_async_start");

    for (int i = 0; i < 15; i++)
      for (int unsigned c = 0; c < tbl[i].cnt; c++)
        step(tbl[i].rn, tbl[i].raw, tbl[i].db, tbl[i].rs, tbl[i].fl, tbl[i].ch);

    // Reset mid-count: bit 5 rises, two mismatch edges counted, then reset.
    for (int c = 0; c < 4; c++)
      step(1'b1, 10'h031, 10'h011, '0, '0, 1'b0);
    @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    cmp(z, "reset_async_midcount");
    for (int c = 0; c < 2; c++)
      step(1'b0, 10'h031, '0, '0, '0, 1'b0);
    // After release a full sync plus 4-clock count is needed again.
    for (int c = 0; c < 5; c++)
      step(1'b1, 10'h031, '0, '0, '0, 1'b0);
    step(1'b1, 10'h031, 10'h031, 10'h031, '0, 1'b1);
    for (int c = 0; c < 3; c++)
      step(1'b1, 10'h031, 10'h031, '0, '0, 1'b0);

    for (int w = 0; w < 20 && sb_q.size() != 0; w++)
      @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port n_reset.
REQ-002 Parameter N, default 10, SHALL be the number of switch bits (SW[9:0] of the cpu board input).
REQ-003 Parameter DB_CYCLES, default 16, SHALL be the number of consecutive clocks a new value must persist before acceptance; legal range 2..65536.
REQ-004 Parameter RESET_VAL, default all-zeros [N-1:0], SHALL be the reset value of sw_db.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 n_reset  input  1  asynchronous active-low reset.
REQ-007 sw_raw  input  N  raw, asynchronous, bouncing switch levels.
REQ-008 sw_db  output  N  debounced, clk-synchronous switch levels; drives cpu SW.
REQ-009 rise  output  N  one-cycle pulse per bit on an accepted 0->1 transition.
REQ-010 fall  output  N  one-cycle pulse per bit on an accepted 1->0 transition.
REQ-011 sw_changed  output  1  one-cycle pulse, OR of all rise and fall bits.

Function
REQ-012 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Each bit SHALL hold a counter of width $clog2(DB_CYCLES) and a two-state FSM: STABLE (sync2 == sw_db), PENDING (sync2 != sw_db).
REQ-014 STABLE -> PENDING when sync2 differs from sw_db; counter increments by 1 on that edge.
REQ-015 In PENDING, counter SHALL increment on every edge where sync2 still differs from sw_db.
REQ-016 When sync2 differs and counter == DB_CYCLES-1, that edge SHALL load sw_db with sync2, clear the counter and return to STABLE.
REQ-017 In PENDING, an edge where sync2 equals sw_db SHALL clear the counter and return to STABLE, with no change to sw_db and no pulse.
REQ-018 Latency: if sw_raw changes and is first sampled at edge k and held, sw_db SHALL update at edge k+1+DB_CYCLES, never earlier.
REQ-019 rise/fall SHALL be registered, asserted in the cycle after the edge that updates sw_db, and deasserted on the next edge.
REQ-020 Bits SHALL be fully independent; simultaneous changes on several bits SHALL give simultaneous updates and a single sw_changed pulse.
REQ-021 The counter SHALL never wrap; it saturates by construction at DB_CYCLES-1.
REQ-022 A bit toggling with a period shorter than DB_CYCLES clocks SHALL never change sw_db.

Reset
REQ-023 On n_reset low, asynchronously: sync1 = sync2 = RESET_VAL, sw_db = RESET_VAL, counters = 0, FSMs = STABLE, rise = fall = 0, sw_changed = 0.
REQ-024 Reset asserted mid-count SHALL discard all partial counts; after release a full DB_CYCLES persistence SHALL again be required.
REQ-025 After release, the first edge SHALL behave as normal operation; no pulses SHALL be generated by reset itself.

Structure
REQ-026 Default N, DB_CYCLES and the per-bit FSM state enum (STABLE, PENDING) SHALL live in the shared cpu package.
REQ-027 Per-bit logic SHALL be a sub-module sw_debounce_bit, instantiated N times by generate; sw_debounce holds only replication and the sw_changed OR.

Verification (N=10, DB_CYCLES=4, RESET_VAL=0)
REQ-028 Reset: n_reset low with sw_raw=10'h3FF -> sw_db=0, rise=fall=0, sw_changed=0, for the whole reset period.
REQ-029 Rise: sw_raw[3] 0->1 first sampled at edge k, held -> sw_db[3]=1 after edge k+5; rise[3] and sw_changed high for exactly one cycle; sw_db[3]=0 after edge k+4.
REQ-030 Glitch: sw_raw[0] high for 3 clocks, then low -> sw_db[0] stays 0; no rise/fall/sw_changed pulse.
REQ-031 Simultaneous: sw_raw[7:0] 0 -> 8'd17 in one cycle -> sw_db[7:0]=17 on a single edge, rise=10'h011, one sw_changed pulse.
REQ-032 Fall and bounce: sw_raw[3] 1->0, 1 for one clock at count 2, then 0 held -> count restarts; sw_db[3]=0 only after 4 consecutive mismatches; fall[3] pulses once.
REQ-033 Reset mid-count: sw_raw[5] rises, n_reset pulsed low after 2 mismatch clocks -> sw_db[5]=0 immediately; after release sw_db[5]=1 only after a full sync and 4-clock count.
